rtc_timekeeper: RTL and testbench

Parametrised real-time clock core that keeps seconds, minutes and hours (24 h) from a free-running system clock via an internal prescaler. It is the successor of the single-field seconds clock: it adds full time-of-day carry, a run/stop control register, range-checked register loads and an optional alarm. It sits between the board clock/reset and the display/bus logic, which loads time through an address/data strobe interface.

---
 rtl/rtc_pkg.sv | 35 +++
 rtl/rtc_timekeeper_if.sv | 25 ++
 rtl/rtc_prescaler.sv | 37 +++
 rtl/rtc_timekeeper.sv | 154 +++++++++++++++
 tb/tb_rtc_timekeeper.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_pkg.sv
// Shared definitions for the real-time clock: register map, field widths,
// field limits and control-register bit positions.
package rtc_pkg;

    localparam int unsigned SEC_W     = 6;
    localparam int unsigned MIN_W     = 6;
    localparam int unsigned HR_W      = 5;
    localparam int unsigned DATA_W    = 6;
    localparam int unsigned ADDR_BITS = 3;

    typedef enum logic [ADDR_BITS-1:0] {
        ADDR_SEC     = 3'b000,
        ADDR_MIN     = 3'b001,
        ADDR_HR      = 3'b010,
        ADDR_CTRL    = 3'b011,
        ADDR_ALM_MIN = 3'b100,
        ADDR_ALM_HR  = 3'b101,
        ADDR_RSVD6   = 3'b110,
        ADDR_RSVD7   = 3'b111
    } rtc_addr_e;

    localparam logic [DATA_W-1:0] SEC_MAX = 6'd59;
    localparam logic [DATA_W-1:0] MIN_MAX = 6'd59;
    localparam logic [DATA_W-1:0] HR_MAX  = 6'd23;

    localparam int unsigned CTRL_RUN     = 0;
    localparam int unsigned CTRL_ALM_EN  = 1;
    localparam int unsigned CTRL_ALM_ACK = 2;

    function automatic logic in_range(input logic [DATA_W-1:0] d,
                                      input logic [DATA_W-1:0] lim);
        return d <= lim;
    endfunction

endpackage

// File: rtl/rtc_timekeeper_if.sv
// Register-load strobe bus and time/status outputs of the RTC core.
interface rtc_timekeeper_if;
    import rtc_pkg::*;

    logic                 load;
    logic [ADDR_BITS-1:0] addrs;
    logic [DATA_W-1:0]    data_in;
    logic [SEC_W-1:0]     seconds_out;
    logic [MIN_W-1:0]     minutes_out;
    logic [HR_W-1:0]      hours_out;
    logic                 tick_1hz;
    logic                 load_err;
    logic                 alarm_irq;

    modport master (
        output load, addrs, data_in,
        input  seconds_out, minutes_out, hours_out, tick_1hz, load_err, alarm_irq
    );

    modport slave (
        input  load, addrs, data_in,
        output seconds_out, minutes_out, hours_out, tick_1hz, load_err, alarm_irq
    );

endinterface

// File: rtl/rtc_prescaler.sv
// Divides the system clock down to a one-cycle tick every DIV cycles while
// running; the count freezes while stopped and clear restarts the period.
module rtc_prescaler #(
    parameter int unsigned DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned    CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_o = run_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = tick_o ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/rtc_timekeeper.sv
// 24 h time-of-day clock with range-checked register loads and run control.
// Optional alarm registers and alarm_irq are built when RTC_ALARM_EN is defined.
module rtc_timekeeper
    import rtc_pkg::*;
#(
    parameter int unsigned DIV    = 100_000_000,
    parameter int unsigned ADDR_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    rtc_timekeeper_if.slave  bus
);

    logic [SEC_W-1:0] sec_q, sec_d;
    logic [MIN_W-1:0] min_q, min_d;
    logic [HR_W-1:0]  hr_q,  hr_d;
    logic             run_q, run_d;
    logic             tick_q, err_q;

    rtc_addr_e addr;
    logic      load_valid, load_ok, sec_load, pre_tick, tick_eff;

    assign addr = rtc_addr_e'(bus.addrs[ADDR_W-1:0]);

    always_comb begin
        load_valid = 1'b0;
        case (addr)
            ADDR_SEC:     load_valid = in_range(bus.data_in, SEC_MAX);
            ADDR_MIN:     load_valid = in_range(bus.data_in, MIN_MAX);
            ADDR_HR:      load_valid = in_range(bus.data_in, HR_MAX);
            ADDR_CTRL:    load_valid = 1'b1;
`ifdef RTC_ALARM_EN
            ADDR_ALM_MIN: load_valid = in_range(bus.data_in, MIN_MAX);
            ADDR_ALM_HR:  load_valid = in_range(bus.data_in, HR_MAX);
`endif
            default:      load_valid = 1'b0;
        endcase
    end

    assign load_ok  = bus.load && load_valid;
    assign sec_load = load_ok && (addr == ADDR_SEC);
    // A seconds load restarts the second, so it swallows a coincident tick.
    assign tick_eff = pre_tick && !sec_load;

    rtc_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk     (clk),
        .rst     (reset),
        .run_i   (run_q),
        .clear_i (sec_load),
        .tick_o  (pre_tick)
    );

    always_comb begin
        sec_d = sec_q;
        min_d = min_q;
        hr_d  = hr_q;
        run_d = run_q;
        if (tick_eff) begin
            if (sec_q == SEC_MAX) begin
                sec_d = '0;
                if (min_q == MIN_MAX) begin
                    min_d = '0;
                    hr_d  = (hr_q == HR_MAX[HR_W-1:0]) ? '0 : hr_q + 1'b1;
                end else begin
                    min_d = min_q + 1'b1;
                end
            end else begin
                sec_d = sec_q + 1'b1;
            end
        end
        // Loaded field overrides the carried value.
        if (load_ok) begin
            case (addr)
                ADDR_SEC:  sec_d = bus.data_in;
                ADDR_MIN:  min_d = bus.data_in;
                ADDR_HR:   hr_d  = bus.data_in[HR_W-1:0];
                ADDR_CTRL: run_d = bus.data_in[CTRL_RUN];
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sec_q  <= '0;
            min_q  <= '0;
            hr_q   <= '0;
            run_q  <= 1'b1;
            tick_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            sec_q  <= sec_d;
            min_q  <= min_d;
            hr_q   <= hr_d;
            run_q  <= run_d;
            tick_q <= tick_eff;
            err_q  <= bus.load && !load_valid;
        end
    end

    assign bus.seconds_out = sec_q;
    assign bus.minutes_out = min_q;
    assign bus.hours_out   = hr_q;
    assign bus.tick_1hz    = tick_q;
    assign bus.load_err    = err_q;

`ifdef RTC_ALARM_EN
    logic [MIN_W-1:0] alm_min_q, alm_min_d;
    logic [HR_W-1:0]  alm_hr_q,  alm_hr_d;
    logic             alm_en_q,  alm_en_d;
    logic             irq_q,     irq_d;
    logic             alm_hit,   alm_ack;

    assign alm_hit = alm_en_q && tick_eff && (sec_d == '0)
                     && (min_d == alm_min_q) && (hr_d == alm_hr_q);
    assign alm_ack = load_ok && (addr == ADDR_CTRL) && bus.data_in[CTRL_ALM_ACK];

    always_comb begin
        alm_min_d = alm_min_q;
        alm_hr_d  = alm_hr_q;
        alm_en_d  = alm_en_q;
        if (load_ok) begin
            case (addr)
                ADDR_ALM_MIN: alm_min_d = bus.data_in;
                ADDR_ALM_HR:  alm_hr_d  = bus.data_in[HR_W-1:0];
                ADDR_CTRL:    alm_en_d  = bus.data_in[CTRL_ALM_EN];
                default:      ;
            endcase
        end
        irq_d = alm_hit ? 1'b1 : (alm_ack ? 1'b0 : irq_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alm_min_q <= '0;
            alm_hr_q  <= '0;
            alm_en_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            alm_min_q <= alm_min_d;
            alm_hr_q  <= alm_hr_d;
            alm_en_q  <= alm_en_d;
            irq_q     <= irq_d;
        end
    end

    assign bus.alarm_irq = irq_q;
`else
    assign bus.alarm_irq = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Self-checking bench for rtc_timekeeper: load table, directed corner sequences
// and randomized loads against a seconds-of-day reference model.
module tb_rtc_timekeeper;

    localparam int unsigned DIV = 10;
    localparam int DAY = 86400;

    logic clk = 1'b0;
    logic reset = 1'b1;

    rtc_timekeeper_if bus ();

    rtc_timekeeper #(
        .DIV    (DIV),
        .ADDR_W (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int tick_seen = 0;
    int irq_seen  = 0;

    // reference model: time kept as seconds since midnight
    int m_tod, m_pre, m_run, m_alen, m_amin, m_ahr, m_irq, m_tick, m_err;

    typedef struct {
        bit ld;
        int addr;
        int data;
        bit err;
        int h;
        int m;
        int s;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit addr_ok(input int a, input int d);
        case (a)
            0, 1: return d <= 59;
            2:    return d <= 23;
            3:    return 1'b1;
`ifdef RTC_ALARM_EN
            4:    return d <= 59;
            5:    return d <= 23;
`endif
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_tod = 0; m_pre = 0; m_run = 1; m_alen = 0; m_amin = 0; m_ahr = 0;
        m_irq = 0; m_tick = 0; m_err = 0;
    endtask

    task automatic model_step(input bit ld, input int a, input int d);
        bit t, ok, eff, set, ack;
        int npre, ntod, h, mi, s;
        t    = (m_run != 0) && (m_pre == DIV - 1);
        ok   = ld && addr_ok(a, d);
        npre = (m_run != 0) ? (t ? 0 : m_pre + 1) : m_pre;
        eff  = t && !(ok && a == 0);
        ntod = eff ? (m_tod + 1) % DAY : m_tod;
        h = ntod / 3600; mi = (ntod / 60) % 60; s = ntod % 60;
        ack = 0;
        if (ok) begin
            case (a)
                0: begin s = d; npre = 0; end
                1: mi = d;
                2: h = d;
                default: ;
            endcase
        end
        ntod = h * 3600 + mi * 60 + s;
        set = 0;
`ifdef RTC_ALARM_EN
        set = (m_alen != 0) && eff && (ntod == m_ahr * 3600 + m_amin * 60);
        if (ok && a == 3) begin m_alen = (d >> 1) & 1; ack = ((d >> 2) & 1) != 0; end
        if (ok && a == 4) m_amin = d;
        if (ok && a == 5) m_ahr = d;
`endif
        if (ok && a == 3) m_run = d & 1;
        m_irq  = set ? 1 : (ack ? 0 : m_irq);
        m_tick = eff;
        m_err  = ld && !addr_ok(a, d);
        m_pre  = npre;
        m_tod  = ntod;
    endtask

    function automatic logic [31:0] model_vec();
        logic [31:0] v;
        v = {12'd0, 6'(m_tod % 60), 6'((m_tod / 60) % 60), 5'(m_tod / 3600),
             1'(m_tick), 1'(m_err), 1'(m_irq)};
        return v;
    endfunction

    function automatic logic [31:0] dut_vec();
        logic [31:0] v;
        v = {12'd0, bus.seconds_out, bus.minutes_out, bus.hours_out,
             bus.tick_1hz, bus.load_err, bus.alarm_irq};
        return v;
    endfunction

    function automatic logic [31:0] hms(input int h, input int m, input int s);
        return 32'(h * 10000 + m * 100 + s);
    endfunction

    function automatic logic [31:0] dut_hms();
        return hms(int'(bus.hours_out), int'(bus.minutes_out), int'(bus.seconds_out));
    endfunction

    task automatic cycle(input bit ld, input int a, input int d);
        bus.load    = ld;
        bus.addrs   = 3'(a);
        bus.data_in = 6'(d);
        @(posedge clk);
        model_step(ld, a, d);
        #1;
        chk("model", dut_vec(), model_vec());
        tick_seen += int'(bus.tick_1hz);
        irq_seen  += int'(bus.alarm_irq);
        bus.load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 0);
    endtask

    initial begin
        bus.load = 1'b0; bus.addrs = '0; bus.data_in = '0;
        model_reset();

        tbl[0]  = '{1, 0, 58, 0,  0,  0, 58};
        tbl[1]  = '{1, 1, 59, 0,  0, 59, 58};
        tbl[2]  = '{1, 2, 23, 0, 23, 59, 58};
        tbl[3]  = '{1, 0, 60, 1, 23, 59, 58};
        tbl[4]  = '{1, 2, 24, 1, 23, 59, 58};
        tbl[5]  = '{1, 7,  5, 1, 23, 59, 58};
        tbl[6]  = '{1, 6,  5, 1, 23, 59, 58};
        tbl[7]  = '{1, 1, 60, 1, 23, 59, 58};
        tbl[8]  = '{1, 1,  0, 0, 23,  0, 58};
`ifdef RTC_ALARM_EN
        tbl[9]  = '{1, 4,  5, 0, 23,  0, 58};
`else
        tbl[9]  = '{1, 4,  5, 1, 23,  0, 58};
`endif
        tbl[10] = '{1, 5, 24, 1, 23,  0, 58};
        tbl[11] = '{1, 3,  0, 0, 23,  0, 58};

        // reset: outputs held at zero
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("reset_zero", dut_vec(), 32'd0);
        end
        reset = 1'b0;

        // first ticks exactly DIV cycles apart
        tick_seen = 0;
        idle(9);
        chk("first_tick_none", 32'(tick_seen), 32'd0);
        idle(1);
        chk("first_tick", {31'd0, bus.tick_1hz}, 32'd1);
        chk("sec_1", dut_hms(), hms(0, 0, 1));
        idle(10);
        chk("sec_2", dut_hms(), hms(0, 0, 2));

        // register load table, clock stopped
        cycle(1, 3, 0);
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].ld, tbl[i].addr, tbl[i].data);
            chk($sformatf("tbl%0d_err", i), {31'd0, bus.load_err}, {31'd0, tbl[i].err});
            chk($sformatf("tbl%0d_time", i), dut_hms(), hms(tbl[i].h, tbl[i].m, tbl[i].s));
        end

        // midnight rollover
        cycle(1, 3, 1);
        cycle(1, 2, 23); cycle(1, 1, 59); cycle(1, 0, 58);
        idle(10);
        chk("roll_t1", dut_hms(), hms(23, 59, 59));
        chk("roll_tick1", {31'd0, bus.tick_1hz}, 32'd1);
        idle(10);
        chk("roll_t2", dut_hms(), hms(0, 0, 0));
        chk("roll_tick2", {31'd0, bus.tick_1hz}, 32'd1);

        // stop mid-count, resume from frozen count
        cycle(1, 0, 0);
        idle(5);
        cycle(1, 3, 0);
        tick_seen = 0;
        idle(25);
        chk("stop_no_tick", 32'(tick_seen), 32'd0);
        chk("stop_frozen", dut_hms(), hms(0, 0, 0));
        cycle(1, 3, 1);
        idle(3);
        chk("resume_wait", 32'(tick_seen), 32'd0);
        idle(1);
        chk("resume_tick", {31'd0, bus.tick_1hz}, 32'd1);
        chk("resume_time", dut_hms(), hms(0, 0, 1));

        // loads coinciding with the tick
        cycle(1, 2, 0); cycle(1, 1, 5); cycle(1, 0, 59);
        idle(9);
        cycle(1, 1, 10);
        chk("ldmin_tick_time", dut_hms(), hms(0, 10, 0));
        chk("ldmin_tick", {31'd0, bus.tick_1hz}, 32'd1);
        idle(9);
        cycle(1, 0, 30);
        chk("ldsec_tick_time", dut_hms(), hms(0, 10, 30));
        chk("ldsec_no_tick", {31'd0, bus.tick_1hz}, 32'd0);
        tick_seen = 0;
        idle(9);
        chk("ldsec_wait", 32'(tick_seen), 32'd0);
        idle(1);
        chk("ldsec_next", dut_hms(), hms(0, 10, 31));

        // alarm
`ifdef RTC_ALARM_EN
        cycle(1, 4, 1); cycle(1, 5, 0); cycle(1, 3, 3);
        cycle(1, 2, 0); cycle(1, 1, 0); cycle(1, 0, 58);
        irq_seen = 0;
        idle(19);
        chk("alm_early", 32'(irq_seen), 32'd0);
        idle(1);
        chk("alm_set", {31'd0, bus.alarm_irq}, 32'd1);
        chk("alm_time", dut_hms(), hms(0, 1, 0));
        idle(5);
        chk("alm_hold", {31'd0, bus.alarm_irq}, 32'd1);
        cycle(1, 3, 7);
        chk("alm_ack", {31'd0, bus.alarm_irq}, 32'd0);
        cycle(1, 3, 1);
`else
        cycle(1, 4, 1);
        chk("alm_addr_err", {31'd0, bus.load_err}, 32'd1);
        cycle(1, 3, 3);
        cycle(1, 2, 0); cycle(1, 1, 0); cycle(1, 0, 58);
        irq_seen = 0;
        idle(25);
        chk("alm_off", 32'(irq_seen), 32'd0);
        cycle(1, 3, 1);
`endif

        // asynchronous reset mid-count
        idle(7);
        #3 reset = 1'b1;
        #1;
        chk("async_reset", dut_vec(), 32'd0);
        model_reset();
        @(posedge clk); #1;
        chk("reset_hold", dut_vec(), 32'd0);
        reset = 1'b0;
        tick_seen = 0;
        idle(9);
        chk("post_reset_wait", 32'(tick_seen), 32'd0);
        idle(1);
        chk("post_reset_tick", dut_hms(), hms(0, 0, 1));

        // randomized loads against the model
        for (int i = 0; i < 3000; i++) begin
            if (($urandom % 6) == 0) begin
                int a, d;
                a = int'($urandom % 8);
                case ($urandom % 3)
                    0: d = int'($urandom % 24);
                    1: d = int'($urandom % 60);
                    default: d = int'($urandom % 64);
                endcase
                if (a == 3) d = (($urandom % 8) == 0) ? (d & ~1) : (d | 1);
                cycle(1, a, d);
            end else begin
                cycle(0, 0, 0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
